// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and default parameters for the SDRAM port arbiter
package sdram_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic mid_t;
  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MAX_PENDING = 4;
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: in-order FIFO of master ids for outstanding reads
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PENDING,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  mid_t          din,
  output mid_t          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  mid_t          mem_q [DEPTH];
  mid_t          mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // pointer, count and storage updates; pointers wrap naturally at DEPTH
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin two-master Avalon-MM arbiter with in-order read response routing
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  localparam int BW = DATA_W / 8,
  localparam int CW = $clog2(MAX_PENDING) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BW-1:0]     m0_byteenable,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BW-1:0]     m1_byteenable,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BW-1:0]     s_byteenable,
  input  logic              s_waitrequest,
  input  logic              s_readdatavalid,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              rsp_error
);
  state_t        state_q, state_d;
  mid_t          owner_q, owner_d, last_q, last_d, head;
  logic          rsp_error_q, rsp_error_d;
  logic          m0_req, m1_req, own_req, oth_req, busy, rd_block, accept, push, pop;
  logic          full, empty;
  logic [CW-1:0] pend_cnt;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;
  assign own_req = owner_q ? m1_req : m0_req;
  assign oth_req = owner_q ? m0_req : m1_req;
  assign busy = state_q == BUSY;
  assign rd_block = pend_cnt == CW'(MAX_PENDING);
  assign s_address = owner_q ? m1_address : m0_address;
  assign s_writedata = owner_q ? m1_writedata : m0_writedata;
  assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
  assign s_read = busy & (owner_q ? m1_read : m0_read) & ~rd_block;
  assign s_write = busy & (owner_q ? m1_write : m0_write);
  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign m0_waitrequest = ~(accept & ~owner_q);
  assign m1_waitrequest = ~(accept & owner_q);
  assign push = accept & s_read & (~full | pop);
  assign pop = s_readdatavalid & ~empty;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign rsp_error = rsp_error_q;

  sdram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (owner_q),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (pend_cnt)
  );

  // grant FSM: owner is frozen while a presented command waits for acceptance
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    rsp_error_d = rsp_error_q | (s_readdatavalid & empty);
    if (!busy) begin
      if (m0_req | m1_req) begin
        state_d = BUSY;
        owner_d = (m0_req & m1_req) ? ~last_q : m1_req;
      end
    end else if (accept) begin
      last_d = owner_q;
      owner_d = oth_req ? ~owner_q : owner_q;
    end else if (!(s_read | s_write)) begin
      if (oth_req) owner_d = ~owner_q;
      else if (!own_req) state_d = IDLE;
    end
  end

  // FSM registers; last starts at m1 so m0 wins the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      rsp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      rsp_error_q <= rsp_error_d;
    end
  end
endmodule
